// File: rtl/bridge_sensor_conditioner.sv
// Bridge sensor conditioner: sync + debounce of four field contacts.
// Optional stuck-beam fault detection under BRIDGE_SENSOR_FAULT_EN.
module bridge_sensor_conditioner #(
  parameter int DB_CYCLES    = 16,
  parameter int DB_W         = 8,
  parameter int FAULT_CYCLES = 1000,
  parameter int FAULT_W      = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic CarInRaw,
  input  logic CarOutRaw,
  input  logic BoatRaw,
  input  logic PwrBtnRaw,
  output logic CAIN,
  output logic CAO,
  output logic BS,
  output logic PB,
  output logic Fault
);

  localparam int NCH = 4;
  localparam int CH_IN  = 0;
  localparam int CH_OUT = 1;
  localparam int CH_BT  = 2;
  localparam int CH_PB  = 3;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1_q;
  logic [NCH-1:0] s2_q;
  logic [NCH-1:0] stable_q;
  logic [NCH-1:0] stable_d;
  logic [NCH-1:0] rise_d;
  logic [DB_W-1:0] cnt_q [NCH];
  logic [DB_W-1:0] cnt_d [NCH];
  logic cain_q;
  logic cao_q;
  logic pb_q;

  assign raw = {PwrBtnRaw, BoatRaw, CarOutRaw, CarInRaw};

  // Debounce next-state: accept s2 only after DB_CYCLES differing samples
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = s2_q[i];
          rise_d[i]   = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Synchronizers, debouncers and edge-derived outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      cain_q   <= 1'b0;
      cao_q    <= 1'b0;
      pb_q     <= 1'b0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      cain_q   <= rise_d[CH_IN];
      cao_q    <= rise_d[CH_OUT];
      pb_q     <= pb_q ^ rise_d[CH_PB];
    end
  end

  assign CAIN = cain_q;
  assign CAO  = cao_q;
  assign BS   = stable_q[CH_BT];
  assign PB   = pb_q;

`ifdef BRIDGE_SENSOR_FAULT_EN
  localparam logic [FAULT_W-1:0] F_LIM = FAULT_W'(FAULT_CYCLES);

  logic [FAULT_W-1:0] fin_q, fin_d;
  logic [FAULT_W-1:0] fout_q, fout_d;
  logic fault_q, fault_d;

  // Blocked-time counters; saturate so a long block cannot wrap
  always_comb begin
    fin_d  = '0;
    fout_d = '0;
    if (stable_q[CH_IN])
      fin_d = (fin_q == '1) ? fin_q : fin_q + 1'b1;
    if (stable_q[CH_OUT])
      fout_d = (fout_q == '1) ? fout_q : fout_q + 1'b1;
    fault_d = fault_q | (fin_d >= F_LIM) | (fout_d >= F_LIM);
  end

  // Fault counters and sticky flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fin_q   <= '0;
      fout_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      fin_q   <= fin_d;
      fout_q  <= fout_d;
      fault_q <= fault_d;
    end
  end

  assign Fault = fault_q;
`else
  logic unused_fault_cfg;
  assign unused_fault_cfg = ^{FAULT_CYCLES[0], FAULT_W[0]};
  assign Fault = 1'b0;
`endif

endmodule
